load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit: single-outstanding core-to-memory byte/half/word access |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_store_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        access_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_size_b  = 3'd0;
  localparam logic [2:0] c_size_h  = 3'd1;
  localparam logic [2:0] c_size_w  = 3'd2;
  localparam logic [2:0] c_size_bu = 3'd4;
  localparam logic [2:0] c_size_hu = 3'd5;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [31:0] r_rd;
  logic [2:0]  r_size;
  logic        r_we;

  logic        w_illegal;
  logic        w_misaligned;
  logic        w_bad;
  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_wd_rep;
  logic [31:0] w_rd_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Unsigned sizes only make sense for loads.
  always_comb begin
    w_illegal = 1'b0;
    case (core_size_i)
      c_size_b, c_size_h, c_size_w: w_illegal = 1'b0;
      c_size_bu, c_size_hu:         w_illegal = core_we_i;
      default:                      w_illegal = 1'b1;
    endcase
  end

  assign w_misaligned = ((core_size_i[1:0] == 2'd1) && core_addr_i[0]) ||
                        ((core_size_i == c_size_w) && (core_addr_i[1:0] != 2'b00));
  assign w_bad        = w_illegal || w_misaligned;
  assign w_accept     = (r_state == S_IDLE) && core_req_i && !w_bad;

  always_comb begin
    w_state_nxt  = r_state;
    core_stall_o = 1'b0;
    access_err_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (core_req_i) begin
          if (w_bad) begin
            access_err_o = 1'b1;
          end else begin
            core_stall_o = 1'b1;
            w_state_nxt  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        core_stall_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = r_we;
        mem_be_o     = w_be;
        if (mem_ready_i) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory-side lane steering works only from captured request fields.
  always_comb begin
    case (r_size[1:0])
      2'd0:    w_be = 4'b0001 << r_addr[1:0];
      2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    case (r_size[1:0])
      2'd0:    w_wd_rep = {4{r_wd[7:0]}};
      2'd1:    w_wd_rep = {2{r_wd[15:0]}};
      default: w_wd_rep = r_wd;
    endcase
  end

  assign w_byte = mem_rd_i[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

  always_comb begin
    case (r_size)
      c_size_b:  w_rd_ext = {{24{w_byte[7]}}, w_byte};
      c_size_bu: w_rd_ext = {24'd0, w_byte};
      c_size_h:  w_rd_ext = {{16{w_half[15]}}, w_half};
      c_size_hu: w_rd_ext = {16'd0, w_half};
      default:   w_rd_ext = mem_rd_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr <= 32'd0;
      r_wd   <= 32'd0;
      r_size <= 3'd0;
      r_we   <= 1'b0;
      r_rd   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addr <= core_addr_i;
        r_wd   <= core_wd_i;
        r_size <= core_size_i;
        r_we   <= core_we_i;
      end
      if ((r_state == S_BUSY) && mem_ready_i && !r_we) begin
        r_rd <= w_rd_ext;
      end
    end
  end

  assign core_rd_o  = r_rd;
  assign mem_addr_o = {r_addr[31:2], 2'b00};
  assign mem_wd_o   = w_wd_rep;

endmodule
`default_nettype wire
